uart_ctrl: RTL and testbench

Parametrised single-clock-domain UART controller: TX and RX FIFOs, a runtime-programmable baud divider, configurable parity and stop bits, sticky error flags and RTS/CTS flow control.
- All logic runs on i_clk, gated by clock enables. There is no derived baud clock and no clock-domain crossing handshakes.
- Sits between the bus register block and the pads, and is the successor to the current UART top.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/fifo.sv | 46 ++++
 rtl/uart_tick_gen.sv | 22 ++
 rtl/uart_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default oversample width and parity helper
// for the uart_ctrl block.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int OverSampleDflt = 16;
    localparam int CntWidth       = $clog2(OverSampleDflt);

    function automatic logic parity_f(input logic [8:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/fifo.sv
// fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Push on full is accepted only together with a pop.
module fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [Width-1:0]           i_data,
    input  logic                       i_pop,
    output logic [Width-1:0]           o_data,
    output logic [$clog2(Depth):0]     o_count
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign do_rd   = i_pop && (cnt_q != '0);
    assign do_wr   = i_push && ((cnt_q != CW'(Depth)) || do_rd);
    assign cnt_d   = cnt_q + CW'(do_wr) - CW'(do_rd);
    assign o_data  = mem_q[rd_q];
    assign o_count = cnt_q;

    // storage, pointers (wrap naturally at Depth) and count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_q] <= i_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_rd) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running baud tick, one-cycle pulse every i_div+1 clocks.
// A new divider value is picked up at the next reload.
module uart_tick_gen #(
    parameter int DivWidth = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DivWidth-1:0] i_div,
    output logic                o_tick
);
    logic [DivWidth-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == '0);
    assign cnt_d  = o_tick ? i_div : cnt_q - 1'b1;

    // down-counter with reload on terminal count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: UART with TX/RX FIFOs, programmable baud, parity, RTS/CTS.
// Define UART_LOOPBACK_EN to add i_loopback (internal serial loopback).
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int DataWidth    = 8,
    parameter int FifoDepth    = 16,
    parameter int OverSample   = 16,
    parameter int DivWidth     = 16,
    parameter int RtsThreshold = FifoDepth - 2
) (
`ifdef UART_LOOPBACK_EN
    input  logic                 i_loopback,
`endif
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DivWidth-1:0]  i_baud_div,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_two_stop,
    input  logic                 i_flow_en,
    input  logic [DataWidth-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DataWidth-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    input  logic                 i_err_clr,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_tx_busy,
    input  logic                 i_rx,
    output logic                 o_tx,
    input  logic                 i_cts_n,
    output logic                 o_rts_n
);
    localparam int CntW = $clog2(OverSample);
    localparam int FcW  = $clog2(FifoDepth) + 1;
    localparam logic [CntW-1:0] OsLast   = CntW'(OverSample - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(OverSample / 2 - 1);
    localparam logic [3:0]      BitLast  = 4'(DataWidth - 1);
    localparam logic [FcW-1:0]  RtsLvl   = FcW'(RtsThreshold);
    localparam logic [FcW-1:0]  FullLvl  = FcW'(FifoDepth);

    logic                 tick;
    logic [FcW-1:0]       tx_count, rx_count;
    logic [DataWidth-1:0] tx_head;
    logic                 tx_pop, tx_go, rx_push, rx_full, rx_smp_stop, rx_src;

    uart_state_e          tx_st_q, rx_st_q;
    logic [CntW-1:0]      tx_cnt_q, rx_cnt_q;
    logic [3:0]           tx_idx_q, rx_idx_q;
    logic [DataWidth-1:0] tx_sh_q, rx_sh_q;
    logic                 tx_par_q, tx_stop2_q, tx_q;
    logic                 rx_par_q, fe_q, pe_q, ov_q, rts_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q, cts_s1_q, cts_s2_q;

    uart_tick_gen #(.DivWidth(DivWidth)) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_div   (i_baud_div),
        .o_tick  (tick)
    );

    fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_tx_valid && o_tx_ready),
        .i_data  (i_tx_data),
        .i_pop   (tx_pop),
        .o_data  (tx_head),
        .o_count (tx_count)
    );

    fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (rx_push),
        .i_data  (rx_sh_q),
        .i_pop   (o_rx_valid && i_rx_ready),
        .o_data  (o_rx_data),
        .o_count (rx_count)
    );

`ifdef UART_LOOPBACK_EN
    assign rx_src = i_loopback ? tx_q : i_rx;
    assign o_tx   = i_loopback | tx_q;
`else
    assign rx_src = i_rx;
    assign o_tx   = tx_q;
`endif

    assign o_tx_ready   = (tx_count != FullLvl);
    assign o_rx_valid   = (rx_count != '0);
    assign rx_full      = (rx_count == FullLvl);
    assign tx_go        = !i_flow_en || !cts_s2_q;
    assign tx_pop       = (tx_st_q == S_IDLE) && (tx_count != '0) && tx_go;
    assign o_tx_busy    = (tx_st_q != S_IDLE);
    assign rx_smp_stop  = (rx_st_q == S_STOP) && tick && (rx_cnt_q == OsLast);
    assign rx_push      = rx_smp_stop && !rx_full;
    assign o_frame_err  = fe_q;
    assign o_parity_err = pe_q;
    assign o_overrun    = ov_q;
    assign o_rts_n      = rts_q;

    // two-flop synchronisers for the async line inputs, plus edge history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            cts_s1_q  <= 1'b1;
            cts_s2_q  <= 1'b1;
        end else begin
            rx_s1_q   <= rx_src;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            cts_s1_q  <= i_cts_n;
            cts_s2_q  <= cts_s1_q;
        end
    end

    // RTS deasserts once the RX FIFO reaches the threshold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rts_q <= 1'b1;
        else          rts_q <= i_flow_en && (rx_count >= RtsLvl);
    end

    // TX frame sequencer; o_tx is driven straight from tx_q
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_st_q    <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            unique case (tx_st_q)
                S_IDLE: if (tx_pop) begin
                    tx_st_q    <= S_START;
                    tx_q       <= 1'b0;
                    tx_sh_q    <= tx_head;
                    tx_par_q   <= parity_f(9'(tx_head), i_parity_odd);
                    tx_stop2_q <= i_two_stop;
                    tx_cnt_q   <= '0;
                end
                S_START: if (tick) begin
                    if (tx_cnt_q == OsLast) begin
                        tx_cnt_q <= '0;
                        tx_idx_q <= '0;
                        tx_q     <= tx_sh_q[0];
                        tx_st_q  <= S_DATA;
                    end else tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                S_DATA: if (tick) begin
                    if (tx_cnt_q == OsLast) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == BitLast) begin
                            tx_st_q <= i_parity_en ? S_PARITY : S_STOP;
                            tx_q    <= i_parity_en ? tx_par_q : 1'b1;
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_q     <= tx_sh_q[1];
                        end
                    end else tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                S_PARITY: if (tick) begin
                    if (tx_cnt_q == OsLast) begin
                        tx_cnt_q <= '0;
                        tx_q     <= 1'b1;
                        tx_st_q  <= S_STOP;
                    end else tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                S_STOP: if (tick) begin
                    if (tx_cnt_q == OsLast) begin
                        tx_cnt_q <= '0;
                        if (tx_stop2_q) tx_stop2_q <= 1'b0;
                        else            tx_st_q    <= S_IDLE;
                    end else tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                default: tx_st_q <= S_IDLE;
            endcase
        end
    end

    // RX frame sequencer and sticky errors; a frame only starts on a
    // 1->0 edge, so after a break the line must return high first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_st_q  <= S_IDLE;
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
            rx_sh_q  <= '0;
            rx_par_q <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            if (i_err_clr) begin
                fe_q <= 1'b0;
                pe_q <= 1'b0;
                ov_q <= 1'b0;
            end
            unique case (rx_st_q)
                S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rx_st_q  <= S_START;
                    rx_cnt_q <= '0;
                end
                S_START: if (tick) begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= '0;
                        rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
                    end else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                S_DATA: if (tick) begin
                    if (rx_cnt_q == OsLast) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[DataWidth-1:1]};
                        if (rx_idx_q == BitLast)
                            rx_st_q <= i_parity_en ? S_PARITY : S_STOP;
                        else
                            rx_idx_q <= rx_idx_q + 1'b1;
                    end else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                S_PARITY: if (tick) begin
                    if (rx_cnt_q == OsLast) begin
                        rx_cnt_q <= '0;
                        rx_par_q <= rx_s2_q;
                        rx_st_q  <= S_STOP;
                    end else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                S_STOP: if (tick) begin
                    if (rx_smp_stop) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= S_IDLE;
                        if (!rx_s2_q) fe_q <= 1'b1;
                        if (i_parity_en &&
                            (parity_f(9'(rx_sh_q), i_parity_odd) != rx_par_q))
                            pe_q <= 1'b1;
                        if (rx_full) ov_q <= 1'b1;
                    end else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                default: rx_st_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl (default build).
// Serial loopback is done with a bench-side mux from o_tx to i_rx.
module tb_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        par_en, par_odd, two_stop, flow_en;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, err_clr;
    logic        fe, pe, ov, busy, tx, cts_n, rts_n;
    logic        lb_wire, rx_drv, rx_line;

    int          errors = 0;
    int          checks = 0;
    int          n;
    int          bitclk;
    logic        fe_seen, tx_min;
    logic [11:0] bits;

    always #5 clk = ~clk;

    assign rx_line = lb_wire ? tx : rx_drv;

    uart_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_baud_div   (baud_div),
        .i_parity_en  (par_en),
        .i_parity_odd (par_odd),
        .i_two_stop   (two_stop),
        .i_flow_en    (flow_en),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .i_rx_ready   (rx_ready),
        .i_err_clr    (err_clr),
        .o_frame_err  (fe),
        .o_parity_err (pe),
        .o_overrun    (ov),
        .o_tx_busy    (busy),
        .i_rx         (rx_line),
        .o_tx         (tx),
        .i_cts_n      (cts_n),
        .o_rts_n      (rts_n)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx(input logic lvl, input int max, output int cnt);
        cnt = 0;
        while (tx !== lvl && cnt < max) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_rx(input int max);
        for (int i = 0; i < max && !rx_valid; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy; i++) @(negedge clk);
    endtask

    task automatic clr_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic pbit, input logic stopb);
        rx_drv = 1'b0;
        repeat (bitclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (bitclk) @(negedge clk);
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (bitclk) @(negedge clk);
        end
        rx_drv = stopb;
        repeat (bitclk) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        baud_div = 16'd3;
        par_en   = 1'b0;
        par_odd  = 1'b0;
        two_stop = 1'b0;
        flow_en  = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        cts_n    = 1'b0;
        lb_wire  = 1'b1;
        rx_drv   = 1'b1;
        bitclk   = 16;
        fe_seen  = 1'b0;
        bits     = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rts", rts_n, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_rxv", rx_valid, 0);
        check("rst_rxd", rx_data, 0);
        check("rst_flags", {busy, fe, pe, ov}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: loopback 8N1 at div=3 (64 clocks per bit)
        push(8'hA5);
        check("lat_pre", tx, 1);
        @(negedge clk);
        check("lat_fall", tx, 0);
        push(8'h00);
        push(8'hFF);
        wait_tx(1'b1, 200, n);
        check("bit0_rise", tx, 1);
        wait_tx(1'b0, 200, n);
        check("bit_period", n, 64);
        wait_rx(3000);
        check("lb_b0", {rx_valid, rx_data}, {1'b1, 8'hA5});
        pop();
        wait_rx(3000);
        check("lb_b1", {rx_valid, rx_data}, {1'b1, 8'h00});
        pop();
        wait_rx(3000);
        check("lb_b2", {rx_valid, rx_data}, {1'b1, 8'hFF});
        pop();
        check("lb_flags", {fe, pe, ov}, 0);
        wait_idle(2000);
        lb_wire  = 1'b0;
        baud_div = 16'd0;
        repeat (10) @(negedge clk);

        // 2: odd parity, two stop bits on TX; bad parity on RX
        par_en   = 1'b1;
        par_odd  = 1'b1;
        two_stop = 1'b1;
        push(8'h03);
        wait_tx(1'b0, 50, n);
        repeat (8) @(negedge clk);
        bits[0] = tx;
        for (int k = 1; k < 12; k++) begin
            repeat (16) @(negedge clk);
            bits[k] = tx;
        end
        check("tx_2stop_busy", busy, 1);
        repeat (16) @(negedge clk);
        check("tx_done_busy", busy, 0);
        check("tx_par_frame", bits, 12'hE06);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        check("par_err", pe, 1);
        check("par_no_fe", fe, 0);
        check("par_data", {rx_valid, rx_data}, {1'b1, 8'h5A});
        pop();
        clr_err();
        check("par_clr", pe, 0);

        // 3: frame error, clear, set-wins-over-clear
        par_en   = 1'b0;
        two_stop = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        check("fe_set", fe, 1);
        check("fe_data", {rx_valid, rx_data}, {1'b1, 8'h11});
        pop();
        clr_err();
        check("fe_clr", fe, 0);
        fe_seen = 1'b0;
        err_clr = 1'b1;
        fork
            send_frame(8'h22, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (fe) fe_seen = 1'b1;
            end
        join
        err_clr = 1'b0;
        check("fe_set_wins", fe_seen, 1);
        check("fe_data2", {rx_valid, rx_data}, {1'b1, 8'h22});
        pop();
        @(negedge clk);
        check("rx_empty3", rx_valid, 0);

        // 4: overrun and RTS threshold
        flow_en = 1'b1;
        @(negedge clk);
        check("rts_low", rts_n, 0);
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1);
            if (i == 12) check("rts_below", rts_n, 0);
            if (i == 13) check("rts_thr", rts_n, 1);
            if (i == 15) check("ov_full_ok", ov, 0);
        end
        check("ov_set", ov, 1);
        for (int k = 0; k < 16; k++) begin
            check("ov_drain", {rx_valid, rx_data}, {1'b1, 8'(k)});
            pop();
        end
        check("ov_dropped", rx_valid, 0);
        clr_err();
        check("ov_clr", ov, 0);

        // 5: CTS gating
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        push(8'h55);
        push(8'h66);
        tx_min = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tx_min &= tx;
        end
        check("cts_hold_tx", tx_min, 1);
        check("cts_hold_busy", busy, 0);
        lb_wire = 1'b1;
        cts_n   = 1'b0;
        wait_tx(1'b0, 50, n);
        check("cts_go", tx, 0);
        repeat (40) @(negedge clk);
        cts_n = 1'b1;
        repeat (400) @(negedge clk);
        check("cts_first", {rx_valid, rx_data}, {1'b1, 8'h55});
        pop();
        check("cts_second_held", {rx_valid, busy, tx}, 3'b001);
        cts_n = 1'b0;
        wait_rx(400);
        check("cts_second", {rx_valid, rx_data}, {1'b1, 8'h66});
        pop();
        wait_idle(100);

        // 6: glitch reject, then reset mid-TX
        flow_en = 1'b0;
        lb_wire = 1'b0;
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_rxv", rx_valid, 0);
        check("glitch_flags", {fe, pe, ov}, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("pre_rst_rx", {rx_valid, rx_data}, {1'b1, 8'h3C});
        push(8'h00);
        push(8'h00);
        wait_tx(1'b0, 50, n);
        repeat (40) @(negedge clk);
        check("mid_frame_low", tx, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx, 1);
        check("rst_async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rxv", rx_valid, 0);
        check("post_rst_ready", tx_ready, 1);
        tx_min = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tx_min &= tx;
        end
        check("post_rst_txq", {tx_min, busy}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
